stream_scheduler: RTL and testbench
===================================

STREAM_SCHEDULER -- requirements
Module: stream_scheduler

Interface
REQ-001 Parameter DWIDTH, default 16, sample width in bits.
REQ-002 Parameter NR_STREAMS, default 16, number of interleaved streams sharing the resampling filter.
REQ-003 Parameter NR_STREAMS_LOG, default 4, pointer width.
REQ-004 Parameter PRIME, default 2, number of filter output transfers discarded after reset (filter pipeline fill).
REQ-005 clk  in  1  the single clock; all state on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 src_valid  in  NR_STREAMS  per-stream input sample present.
REQ-008 src_ready  out  NR_STREAMS  per-stream input slot empty.
REQ-009 src_data  in  NR_STREAMS*DWIDTH  stream k at bits k*DWIDTH..k*DWIDTH+DWIDTH-1.
REQ-010 flt_req_in  in  1  filter requests an input sample.
REQ-011 flt_ack_in  out  1  input sample presented to filter.
REQ-012 flt_data_in  out  DWIDTH  sample to filter.
REQ-013 flt_req_out  in  1  filter offers an output sample.
REQ-014 flt_ack_out  out  1  output sample accepted.
REQ-015 flt_data_out  in  DWIDTH  filter output sample.
REQ-016 dst_valid  out  NR_STREAMS  per-stream output slot full.
REQ-017 dst_ready  in  NR_STREAMS  per-stream sink accepts.
REQ-018 dst_data  out  NR_STREAMS*DWIDTH  same slicing as src_data.
REQ-019 in_ptr, out_ptr  out  NR_STREAMS_LOG each  current input/output stream index.
REQ-020 starve  out  1  one-cycle pulse: filter requested input, selected slot empty.

Function
REQ-021 Each stream SHALL own a one-entry input slot; src_ready[k] = !full[k]; slot loads on src_valid[k]&&src_ready[k].
REQ-022 Input FSM states IN_IDLE, IN_ACK, IN_WAIT; streams SHALL be served strictly in order in_ptr = 0..NR_STREAMS-1, wrapping to 0.
REQ-023 IN_IDLE: if flt_req_in && full[in_ptr], next cycle flt_ack_in=1, flt_data_in=slot[in_ptr], go IN_ACK; if flt_req_in && !full[in_ptr], pulse starve and stay.
REQ-024 IN_ACK lasts exactly one cycle; at its end slot[in_ptr] clears and in_ptr advances; go IN_IDLE if an output transfer (flt_req_out&&flt_ack_out) occurs that cycle, else IN_WAIT.
REQ-025 IN_WAIT: hold flt_ack_in=0 until an output transfer completes, then IN_IDLE; at most one input transfer per output transfer.
REQ-026 Output FSM states OUT_IDLE, OUT_ACK; OUT_IDLE: if flt_req_out && (prime_cnt>0 || !dst_full[out_ptr]), next cycle flt_ack_out=1, go OUT_ACK.
REQ-027 OUT_ACK lasts one cycle; at its end flt_data_out SHALL be captured into dst slot[out_ptr] unless prime_cnt>0, in which case prime_cnt decrements and the sample is dropped; out_ptr advances with wrap.
REQ-028 Priming transfers SHALL NOT advance out_ptr; first routed output goes to stream 0.
REQ-029 dst_valid[k] = dst_full[k]; slot clears on dst_valid[k]&&dst_ready[k]; a slot is written only when empty, so no simultaneous write/clear.
REQ-030 Samples SHALL pass unmodified, no width conversion; flt_data_in holds its value outside IN_ACK.
REQ-031 flt_ack_in and flt_ack_out SHALL be registered, never combinational from inputs.

Reset
REQ-032 While rst=1: FSMs IN_IDLE/OUT_IDLE, all slots empty, in_ptr=out_ptr=0, prime_cnt=PRIME, flt_ack_in=flt_ack_out=starve=0, flt_data_in=0, dst_data=0.
REQ-033 Reset asserted mid-transfer SHALL abort it; samples held in slots are discarded.

Structure
REQ-034 DWIDTH, NR_STREAMS, NR_STREAMS_LOG and FSM state encodings SHALL live in shared package resampler_pkg.
REQ-035 One sub-module stream_slot (one-entry register with full flag, load/clear) SHALL be instantiated 2*NR_STREAMS times.

Verification
REQ-036 Streams 0..15 each present sample 0x0100+k, filter model holds req_in and answers each ack with req_out -> filter receives 0x0100..0x010F in order, one per output transfer.
REQ-037 Stream 3 slot empty when in_ptr=3 -> starve pulses each request cycle, flt_ack_in stays 0, streams 4..15 not served until stream 3 supplies.
REQ-038 Filter outputs 0xAAAA, 0xBBBB, then 0x0000..0x000F -> first two dropped, dst_data stream k = 0x000k.
REQ-039 dst_ready[5]=0 with slot 5 full -> flt_ack_out withheld at out_ptr=5 until dst_ready[5]=1; no sample lost.
REQ-040 rst pulsed while IN_ACK active at in_ptr=7 -> next cycle flt_ack_in=0, in_ptr=0, all src_ready=1, prime_cnt=2.

Source files
------------

// File: rtl/resampler_pkg.sv
// Shared widths and FSM state encodings for the multi-stream resampler front end.
package resampler_pkg;

  localparam int DWIDTH         = 16;
  localparam int NR_STREAMS     = 16;
  localparam int NR_STREAMS_LOG = 4;

  typedef enum logic [1:0] {
    IN_IDLE = 2'd0,
    IN_ACK  = 2'd1,
    IN_WAIT = 2'd2
  } in_state_e;

  typedef enum logic {
    OUT_IDLE = 1'b0,
    OUT_ACK  = 1'b1
  } out_state_e;

endpackage

// File: rtl/stream_slot.sv
// One-entry sample buffer with full flag; load takes precedence, data persists after clear.
module stream_slot
  import resampler_pkg::*;
#(
  parameter int W = DWIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic         full,
  output logic [W-1:0] dout
);

  logic         full_q, full_d;
  logic [W-1:0] data_q, data_d;

  // next-state for the slot flag and payload
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (load) begin
      full_d = 1'b1;
      data_d = din;
    end else if (clear) begin
      full_d = 1'b0;
    end else begin
      full_d = full_q;
    end
  end

  // slot state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full = full_q;
  assign dout = data_q;

endmodule

// File: rtl/stream_scheduler.sv
// Round-robin scheduler interleaving NR_STREAMS sample streams through one shared
// resampling filter, with per-stream input/output slots and output pipeline priming.
module stream_scheduler
  import resampler_pkg::in_state_e, resampler_pkg::IN_IDLE, resampler_pkg::IN_ACK,
         resampler_pkg::IN_WAIT, resampler_pkg::out_state_e, resampler_pkg::OUT_IDLE,
         resampler_pkg::OUT_ACK;
#(
  parameter int DWIDTH         = resampler_pkg::DWIDTH,
  parameter int NR_STREAMS     = resampler_pkg::NR_STREAMS,
  parameter int NR_STREAMS_LOG = resampler_pkg::NR_STREAMS_LOG,
  parameter int PRIME          = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NR_STREAMS-1:0]        src_valid,
  output logic [NR_STREAMS-1:0]        src_ready,
  input  logic [NR_STREAMS*DWIDTH-1:0] src_data,
  input  logic                         flt_req_in,
  output logic                         flt_ack_in,
  output logic [DWIDTH-1:0]            flt_data_in,
  input  logic                         flt_req_out,
  output logic                         flt_ack_out,
  input  logic [DWIDTH-1:0]            flt_data_out,
  output logic [NR_STREAMS-1:0]        dst_valid,
  input  logic [NR_STREAMS-1:0]        dst_ready,
  output logic [NR_STREAMS*DWIDTH-1:0] dst_data,
  output logic [NR_STREAMS_LOG-1:0]    in_ptr,
  output logic [NR_STREAMS_LOG-1:0]    out_ptr,
  output logic                         starve
);

  localparam int PW = (PRIME > 0) ? $clog2(PRIME + 1) : 1;
  localparam logic [NR_STREAMS_LOG-1:0] PTR_LAST = NR_STREAMS_LOG'(NR_STREAMS - 1);

  function automatic logic [NR_STREAMS_LOG-1:0] ptr_next(input logic [NR_STREAMS_LOG-1:0] p);
    if (p == PTR_LAST) begin
      ptr_next = '0;
    end else begin
      ptr_next = p + NR_STREAMS_LOG'(1'b1);
    end
  endfunction

  logic [NR_STREAMS-1:0] src_full_s, src_load_s, src_clr_s;
  logic [NR_STREAMS-1:0] dst_full_s, dst_load_s, dst_clr_s;
  logic [DWIDTH-1:0]     src_dout_s [NR_STREAMS];
  logic [DWIDTH-1:0]     dst_dout_s [NR_STREAMS];

  in_state_e                 in_state_q, in_state_d;
  out_state_e                out_state_q, out_state_d;
  logic [NR_STREAMS_LOG-1:0] in_ptr_q, in_ptr_d, out_ptr_q, out_ptr_d;
  logic [PW-1:0]             prime_cnt_q, prime_cnt_d;
  logic                      flt_ack_in_q, flt_ack_in_d;
  logic                      flt_ack_out_q, flt_ack_out_d;
  logic                      starve_q, starve_d;
  logic [DWIDTH-1:0]         flt_data_in_q, flt_data_in_d;
  logic                      out_xfer_s;

  for (genvar k = 0; k < NR_STREAMS; k++) begin : g_slot
    stream_slot #(.W(DWIDTH)) u_src (
      .clk   (clk),
      .rst   (rst),
      .load  (src_load_s[k]),
      .clear (src_clr_s[k]),
      .din   (src_data[k*DWIDTH +: DWIDTH]),
      .full  (src_full_s[k]),
      .dout  (src_dout_s[k])
    );
    stream_slot #(.W(DWIDTH)) u_dst (
      .clk   (clk),
      .rst   (rst),
      .load  (dst_load_s[k]),
      .clear (dst_clr_s[k]),
      .din   (flt_data_out),
      .full  (dst_full_s[k]),
      .dout  (dst_dout_s[k])
    );
    assign dst_data[k*DWIDTH +: DWIDTH] = dst_dout_s[k];
  end

  assign out_xfer_s = flt_req_out && flt_ack_out_q;

  // slot load/clear strobes; dst slots are only loaded when known empty
  always_comb begin
    src_load_s = src_valid & ~src_full_s;
    dst_clr_s  = dst_full_s & dst_ready;
    src_clr_s  = '0;
    dst_load_s = '0;
    if (in_state_q == IN_ACK) begin
      src_clr_s[in_ptr_q] = 1'b1;
    end else begin
      src_clr_s = '0;
    end
    if ((out_state_q == OUT_ACK) && (prime_cnt_q == '0)) begin
      dst_load_s[out_ptr_q] = 1'b1;
    end else begin
      dst_load_s = '0;
    end
  end

  // input FSM: one sample to the filter per output transfer, strictly in stream order
  always_comb begin
    in_state_d    = in_state_q;
    in_ptr_d      = in_ptr_q;
    flt_ack_in_d  = 1'b0;
    flt_data_in_d = flt_data_in_q;
    starve_d      = 1'b0;
    case (in_state_q)
      IN_IDLE: begin
        if (flt_req_in && src_full_s[in_ptr_q]) begin
          flt_ack_in_d  = 1'b1;
          flt_data_in_d = src_dout_s[in_ptr_q];
          in_state_d    = IN_ACK;
        end else if (flt_req_in) begin
          starve_d = 1'b1;
        end else begin
          in_state_d = IN_IDLE;
        end
      end
      IN_ACK: begin
        in_ptr_d = ptr_next(in_ptr_q);
        if (out_xfer_s) begin
          in_state_d = IN_IDLE;
        end else begin
          in_state_d = IN_WAIT;
        end
      end
      IN_WAIT: begin
        if (out_xfer_s) begin
          in_state_d = IN_IDLE;
        end else begin
          in_state_d = IN_WAIT;
        end
      end
      default: begin
        in_state_d = IN_IDLE;
      end
    endcase
  end

  // output FSM: priming transfers are dropped without moving out_ptr
  always_comb begin
    out_state_d   = out_state_q;
    out_ptr_d     = out_ptr_q;
    prime_cnt_d   = prime_cnt_q;
    flt_ack_out_d = 1'b0;
    case (out_state_q)
      OUT_IDLE: begin
        if (flt_req_out && ((prime_cnt_q != '0) || !dst_full_s[out_ptr_q])) begin
          flt_ack_out_d = 1'b1;
          out_state_d   = OUT_ACK;
        end else begin
          out_state_d = OUT_IDLE;
        end
      end
      OUT_ACK: begin
        out_state_d = OUT_IDLE;
        if (prime_cnt_q != '0) begin
          prime_cnt_d = prime_cnt_q - PW'(1'b1);
        end else begin
          out_ptr_d = ptr_next(out_ptr_q);
        end
      end
      default: begin
        out_state_d = OUT_IDLE;
      end
    endcase
  end

  // scheduler state and registered filter-side outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_state_q    <= IN_IDLE;
      out_state_q   <= OUT_IDLE;
      in_ptr_q      <= '0;
      out_ptr_q     <= '0;
      prime_cnt_q   <= PW'(PRIME);
      flt_ack_in_q  <= 1'b0;
      flt_ack_out_q <= 1'b0;
      starve_q      <= 1'b0;
      flt_data_in_q <= '0;
    end else begin
      in_state_q    <= in_state_d;
      out_state_q   <= out_state_d;
      in_ptr_q      <= in_ptr_d;
      out_ptr_q     <= out_ptr_d;
      prime_cnt_q   <= prime_cnt_d;
      flt_ack_in_q  <= flt_ack_in_d;
      flt_ack_out_q <= flt_ack_out_d;
      starve_q      <= starve_d;
      flt_data_in_q <= flt_data_in_d;
    end
  end

  assign src_ready   = ~src_full_s;
  assign dst_valid   = dst_full_s;
  assign flt_ack_in  = flt_ack_in_q;
  assign flt_ack_out = flt_ack_out_q;
  assign flt_data_in = flt_data_in_q;
  assign starve      = starve_q;
  assign in_ptr      = in_ptr_q;
  assign out_ptr     = out_ptr_q;

endmodule

// File: tb/tb_stream_scheduler.sv
// Directed self-checking bench for stream_scheduler with a hand-driven filter handshake.
module tb_stream_scheduler;

  localparam int DW = 16;
  localparam int NS = 16;
  localparam int NL = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NS-1:0]     src_valid;
  logic [NS-1:0]     src_ready;
  logic [NS*DW-1:0]  src_data;
  logic              flt_req_in;
  logic              flt_ack_in;
  logic [DW-1:0]     flt_data_in;
  logic              flt_req_out;
  logic              flt_ack_out;
  logic [DW-1:0]     flt_data_out;
  logic [NS-1:0]     dst_valid;
  logic [NS-1:0]     dst_ready;
  logic [NS*DW-1:0]  dst_data;
  logic [NL-1:0]     in_ptr;
  logic [NL-1:0]     out_ptr;
  logic              starve;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  stream_scheduler #(
    .DWIDTH(DW), .NR_STREAMS(NS), .NR_STREAMS_LOG(NL), .PRIME(2)
  ) dut (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .flt_req_in(flt_req_in), .flt_ack_in(flt_ack_in), .flt_data_in(flt_data_in),
    .flt_req_out(flt_req_out), .flt_ack_out(flt_ack_out), .flt_data_out(flt_data_out),
    .dst_valid(dst_valid), .dst_ready(dst_ready), .dst_data(dst_data),
    .in_ptr(in_ptr), .out_ptr(out_ptr), .starve(starve)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wait_ack_in();
    int n = 0;
    while (flt_ack_in !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ack_in_seen", 32'(flt_ack_in), 32'd1);
  endtask

  task automatic wait_ack_out();
    int n = 0;
    while (flt_ack_out !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ack_out_seen", 32'(flt_ack_out), 32'd1);
  endtask

  task automatic check_dst(input int k, input logic [15:0] val);
    check("dst_valid_k", 32'(dst_valid[k]), 32'd1);
    check("dst_data_k", 32'(dst_data[k*DW +: DW]), 32'(val));
  endtask

  // one input handshake followed by the output transfer it is paired with
  task automatic do_xfer(input logic [15:0] exp_in, input logic [15:0] out_val, input int dst_k);
    wait_ack_in();
    check("data_in", 32'(flt_data_in), 32'(exp_in));
    flt_req_out  = 1'b1;
    flt_data_out = out_val;
    @(negedge clk);
    check("ack_out", 32'(flt_ack_out), 32'd1);
    check("ack_in_wait", 32'(flt_ack_in), 32'd0);
    check("data_in_hold", 32'(flt_data_in), 32'(exp_in));
    @(negedge clk);
    flt_req_out = 1'b0;
    if (dst_k >= 0) check_dst(dst_k, out_val);
  endtask

  task automatic out_only(input logic [15:0] out_val, input int dst_k);
    flt_req_out  = 1'b1;
    flt_data_out = out_val;
    @(negedge clk);
    check("ack_out_only", 32'(flt_ack_out), 32'd1);
    @(negedge clk);
    flt_req_out = 1'b0;
    if (dst_k >= 0) check_dst(dst_k, out_val);
  endtask

  initial begin
    rst = 1'b1;
    src_valid = '0; src_data = '0;
    flt_req_in = 1'b0; flt_req_out = 1'b0; flt_data_out = '0;
    dst_ready = '0;
    repeat (2) @(negedge clk);
    check("rst_src_ready", 32'(src_ready), 32'h0000_FFFF);
    check("rst_dst_valid", 32'(dst_valid), 32'd0);
    check("rst_ack_in", 32'(flt_ack_in), 32'd0);
    check("rst_ack_out", 32'(flt_ack_out), 32'd0);
    check("rst_starve", 32'(starve), 32'd0);
    check("rst_in_ptr", 32'(in_ptr), 32'd0);
    check("rst_out_ptr", 32'(out_ptr), 32'd0);
    check("rst_data_in", 32'(flt_data_in), 32'd0);
    check("rst_dst_data", 32'(dst_data == '0), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // all streams in order; first two filter outputs are priming and dropped
    for (int k = 0; k < NS; k++) src_data[k*DW +: DW] = 16'h0100 + 16'(k);
    src_valid = '1;
    @(negedge clk);
    src_valid = '0;
    check("src_loaded", 32'(src_ready), 32'd0);
    flt_req_in = 1'b1;
    for (int i = 0; i < NS; i++) begin
      if (i == 0)      do_xfer(16'h0100, 16'hAAAA, -1);
      else if (i == 1) do_xfer(16'h0101, 16'hBBBB, -1);
      else             do_xfer(16'h0100 + 16'(i), 16'(i - 2), i - 2);
    end
    flt_req_in = 1'b0;
    out_only(16'h000E, 14);
    out_only(16'h000F, 15);
    check("a_dst_valid", 32'(dst_valid), 32'h0000_FFFF);
    for (int k = 0; k < NS; k++) check("a_dst_data", 32'(dst_data[k*DW +: DW]), 32'(k));
    check("a_out_ptr", 32'(out_ptr), 32'd0);
    check("a_in_ptr", 32'(in_ptr), 32'd0);
    check("a_src_ready", 32'(src_ready), 32'h0000_FFFF);
    dst_ready = '1;
    @(negedge clk);
    check("a_dst_drained", 32'(dst_valid), 32'd0);

    // stream 3 empty: starve until it supplies, later streams wait their turn
    for (int k = 0; k < NS; k++) src_data[k*DW +: DW] = 16'h0200 + 16'(k);
    src_valid = 16'hFFF7;
    @(negedge clk);
    src_valid = '0;
    check("b_src_ready", 32'(src_ready), 32'h0000_0008);
    flt_req_in = 1'b1;
    for (int i = 0; i < 3; i++) do_xfer(16'h0200 + 16'(i), 16'h1000 + 16'(i), i);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("b_starve", 32'(starve), 32'd1);
      check("b_no_ack", 32'(flt_ack_in), 32'd0);
      check("b_in_ptr", 32'(in_ptr), 32'd3);
    end
    src_valid = 16'h0008;
    @(negedge clk);
    src_valid = '0;
    check("b_starve_load", 32'(starve), 32'd1);
    for (int i = 3; i < NS; i++) do_xfer(16'h0200 + 16'(i), 16'h1000 + 16'(i), i);
    flt_req_in = 1'b0;
    check("b_starve_end", 32'(starve), 32'd0);

    // sink 5 stalled: ack_out withheld at out_ptr 5, nothing lost
    dst_ready = 16'hFFDF;
    for (int j = 0; j < 21; j++) out_only(16'h3000 + 16'(j), j % NS);
    check("c_out_ptr", 32'(out_ptr), 32'd5);
    flt_req_out  = 1'b1;
    flt_data_out = 16'h3105;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("c_stall_ack", 32'(flt_ack_out), 32'd0);
      check("c_hold5", 32'(dst_data[5*DW +: DW]), 32'h0000_3005);
    end
    dst_ready = '1;
    wait_ack_out();
    check("c_slot5_freed", 32'(dst_valid[5]), 32'd0);
    @(negedge clk);
    flt_req_out = 1'b0;
    check_dst(5, 16'h3105);

    // reset during IN_ACK at stream 7 aborts everything and re-primes
    for (int k = 0; k < NS; k++) src_data[k*DW +: DW] = 16'h0400 + 16'(k);
    src_valid = '1;
    @(negedge clk);
    src_valid = '0;
    flt_req_in = 1'b1;
    for (int i = 0; i < 7; i++) do_xfer(16'h0400 + 16'(i), 16'h5000 + 16'(i), -1);
    wait_ack_in();
    check("d_in_ptr7", 32'(in_ptr), 32'd7);
    check("d_data7", 32'(flt_data_in), 32'h0000_0407);
    rst = 1'b1;
    flt_req_in = 1'b0;
    @(negedge clk);
    check("d_ack_in", 32'(flt_ack_in), 32'd0);
    check("d_in_ptr", 32'(in_ptr), 32'd0);
    check("d_out_ptr", 32'(out_ptr), 32'd0);
    check("d_src_ready", 32'(src_ready), 32'h0000_FFFF);
    check("d_dst_valid", 32'(dst_valid), 32'd0);
    check("d_data_in", 32'(flt_data_in), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    src_data[0 +: DW] = 16'h0500;
    src_valid = 16'h0001;
    @(negedge clk);
    src_valid = '0;
    flt_req_in = 1'b1;
    do_xfer(16'h0500, 16'hCCCC, -1);
    flt_req_in = 1'b0;
    out_only(16'hDDDD, -1);
    check("d_primed_drop", 32'(dst_valid), 32'd0);
    check("d_primed_ptr", 32'(out_ptr), 32'd0);
    out_only(16'h0042, 0);
    check("d_first_routed_ptr", 32'(out_ptr), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
